// File: rtl/autocat_pkg.sv
// rtl/autocat_pkg.sv - shared FSM state type and width helpers for the way-partitioning profiler
package autocat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCAN,
    ST_UPDATE
  } state_t;

  localparam int ACC_CNT_W = 32;

  function automatic int way_idx_w(input int num_ways);
    return $clog2(num_ways);
  endfunction

  // A single channel still needs a one-bit channel field on the ports.
  function automatic int chan_idx_w(input int num_channels);
    return (num_channels > 1) ? $clog2(num_channels) : 1;
  endfunction

endpackage

// File: rtl/autocat_counter_bank.sv
// rtl/autocat_counter_bank.sv - one channel's cumulative per-way hit counters and access counter
module autocat_counter_bank
  import autocat_pkg::*;
#(
  parameter int NUM_WAYS      = 16,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                           clk_in,
  input  logic                           reset_n_in,
  input  logic                           clear_in,
  input  logic                           count_in,
  input  logic [way_idx_w(NUM_WAYS):0]   hit_pos_in,
  input  logic [way_idx_w(NUM_WAYS)-1:0] rd_idx_in,
  output logic [COUNTER_WIDTH-1:0]       rd_cnt_out,
  output logic [COUNTER_WIDTH-1:0]       total_out,
  output logic [ACC_CNT_W-1:0]           access_cnt_out
);

  logic [COUNTER_WIDTH-1:0] cnt_q [NUM_WAYS];
  logic [ACC_CNT_W-1:0]     acc_q;

  // cnt_q[k] counts hits at stack depth <= k; a miss position never satisfies that.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in || clear_in) begin
      for (int k = 0; k < NUM_WAYS; k++) cnt_q[k] <= '0;
      acc_q <= '0;
    end else if (count_in) begin
      acc_q <= acc_q + 1'b1;
      for (int k = 0; k < NUM_WAYS; k++) begin
        if ((int'(hit_pos_in) <= k) && (cnt_q[k] != '1)) cnt_q[k] <= cnt_q[k] + 1'b1;
      end
    end
  end

  assign rd_cnt_out     = cnt_q[rd_idx_in];
  assign total_out      = cnt_q[NUM_WAYS-1];
  assign access_cnt_out = acc_q;

endmodule

// File: rtl/autocat_mc.sv
// rtl/autocat_mc.sv - per-channel LRU-stack profiler that suggests the smallest adequate way mask
module autocat_mc
  import autocat_pkg::*;
#(
  parameter int NUM_WAYS      = 16,
  parameter int NUM_CHANNELS  = 4,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                                 clk_in,
  input  logic                                 reset_n_in,
  input  logic                                 enable_in,
  input  logic [4:0]                           reset_bin_power_in,
  input  logic [COUNTER_WIDTH-1:0]             allowed_gap_in,
  input  logic [way_idx_w(NUM_WAYS):0]         min_ways_in,
  input  logic                                 access_valid_in,
  input  logic [chan_idx_w(NUM_CHANNELS)-1:0]  access_channel_in,
  input  logic [way_idx_w(NUM_WAYS):0]         hit_pos_in,
  output logic [NUM_CHANNELS*NUM_WAYS-1:0]     suggested_waymask_out,
  output logic                                 update_valid_out,
  output logic [chan_idx_w(NUM_CHANNELS)-1:0]  update_channel_out
);

  localparam int WAY_W = way_idx_w(NUM_WAYS);
  localparam int CH_W  = chan_idx_w(NUM_CHANNELS);

  state_t                            state_q;
  logic [CH_W-1:0]                   sel_q;
  logic [WAY_W-1:0]                  k_q;
  logic [COUNTER_WIDTH-1:0]          total_q;
  logic [NUM_CHANNELS-1:0]           pending_q;
  logic [NUM_CHANNELS*NUM_WAYS-1:0]  mask_q;
  logic                              upd_valid_q;
  logic [CH_W-1:0]                   upd_ch_q;

  logic [NUM_CHANNELS-1:0]  count_v, clear_v, pend_set;
  logic [NUM_CHANNELS-1:0]  pending_d;
  logic [COUNTER_WIDTH-1:0] rd_cnt  [NUM_CHANNELS];
  logic [COUNTER_WIDTH-1:0] tot_cnt [NUM_CHANNELS];
  logic [ACC_CNT_W-1:0]     acc_cnt [NUM_CHANNELS];
  logic [ACC_CNT_W-1:0]     epoch_len;
  logic [CH_W-1:0]          pick_ch;
  logic [COUNTER_WIDTH:0]   scan_sum;
  logic                     scan_hit;
  logic [WAY_W:0]           eff_min, ways_found, new_ways;
  logic [NUM_WAYS-1:0]      new_mask;

  assign epoch_len = {{(ACC_CNT_W-1){1'b0}}, 1'b1} << reset_bin_power_in;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_bank
    // A channel waiting for or under evaluation is frozen so its epoch stays intact.
    assign count_v[c]  = enable_in && access_valid_in && (int'(access_channel_in) == c) &&
                         !pending_q[c] && !((state_q != ST_IDLE) && (int'(sel_q) == c));
    assign clear_v[c]  = !enable_in || ((state_q == ST_UPDATE) && (int'(sel_q) == c));
    assign pend_set[c] = count_v[c] && ((acc_cnt[c] + 1'b1) == epoch_len);

    autocat_counter_bank #(
      .NUM_WAYS      (NUM_WAYS),
      .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_bank (
      .clk_in         (clk_in),
      .reset_n_in     (reset_n_in),
      .clear_in       (clear_v[c]),
      .count_in       (count_v[c]),
      .hit_pos_in     (hit_pos_in),
      .rd_idx_in      (k_q),
      .rd_cnt_out     (rd_cnt[c]),
      .total_out      (tot_cnt[c]),
      .access_cnt_out (acc_cnt[c])
    );
  end

  always_comb begin
    pick_ch = '0;
    for (int c = NUM_CHANNELS-1; c >= 0; c--) begin
      if (pending_q[c]) pick_ch = CH_W'(c);
    end
  end

  always_comb begin
    pending_d = pending_q | pend_set;
    if (state_q == ST_UPDATE) pending_d[sel_q] = 1'b0;
  end

  always_comb begin
    if (min_ways_in == '0)                    eff_min = (WAY_W+1)'(1);
    else if (int'(min_ways_in) > NUM_WAYS)    eff_min = (WAY_W+1)'(NUM_WAYS);
    else                                      eff_min = min_ways_in;
  end

  // One extra bit keeps cnt + gap from wrapping when both are near saturation.
  assign scan_sum   = {1'b0, rd_cnt[sel_q]} + {1'b0, allowed_gap_in};
  assign scan_hit   = scan_sum >= {1'b0, total_q};
  assign ways_found = {1'b0, k_q} + (WAY_W+1)'(1);
  assign new_ways   = (ways_found > eff_min) ? ways_found : eff_min;

  always_comb begin
    new_mask = '0;
    for (int i = 0; i < NUM_WAYS; i++) new_mask[i] = (int'(new_ways) > i);
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n_in || !enable_in) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      k_q         <= '0;
      total_q     <= '0;
      pending_q   <= '0;
      mask_q      <= '1;
      upd_valid_q <= 1'b0;
      upd_ch_q    <= '0;
    end else begin
      upd_valid_q <= 1'b0;
      pending_q   <= pending_d;
      case (state_q)
        ST_IDLE: begin
          if (|pending_q) begin
            sel_q   <= pick_ch;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          total_q <= tot_cnt[sel_q];
          k_q     <= '0;
          state_q <= ST_SCAN;
        end
        ST_SCAN: begin
          // Mask and pulse are registered on entry so they are visible during UPDATE.
          if (scan_hit) begin
            mask_q[int'(sel_q)*NUM_WAYS +: NUM_WAYS] <= new_mask;
            upd_valid_q <= 1'b1;
            upd_ch_q    <= sel_q;
            state_q     <= ST_UPDATE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        ST_UPDATE: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign suggested_waymask_out = mask_q;
  assign update_valid_out      = upd_valid_q;
  assign update_channel_out    = upd_ch_q;

endmodule

// File: tb/tb_autocat_mc.sv
// tb/tb_autocat_mc.sv - directed bench with an epoch-level reference model for autocat_mc
module tb_autocat_mc;

  localparam int NW = 16;
  localparam int NC = 4;
  localparam int CW = 8;
  localparam longint SAT = (longint'(1) << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [4:0]    power;
  logic [CW-1:0] gap;
  logic [4:0]    min_ways;
  logic          access_valid;
  logic [1:0]    access_channel;
  logic [4:0]    hit_pos;
  logic [NC*NW-1:0] wm;
  logic          update_valid;
  logic [1:0]    update_channel;

  always #5 clk = ~clk;

  autocat_mc #(.NUM_WAYS(NW), .NUM_CHANNELS(NC), .COUNTER_WIDTH(CW)) dut (
    .clk_in                (clk),
    .reset_n_in            (reset_n),
    .enable_in             (enable),
    .reset_bin_power_in    (power),
    .allowed_gap_in        (gap),
    .min_ways_in           (min_ways),
    .access_valid_in       (access_valid),
    .access_channel_in     (access_channel),
    .hit_pos_in            (hit_pos),
    .suggested_waymask_out (wm),
    .update_valid_out      (update_valid),
    .update_channel_out    (update_channel)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model state: per-channel hit histogram by stack position and epoch bookkeeping.
  int          hist [NC][NW];
  int          acc_m [NC];
  bit          blocked [NC];
  bit          release_m [NC];
  bit          exp_valid [NC];
  logic [NW-1:0] exp_mask [NC];
  logic [NW-1:0] model_mask [NC];
  int          pulse_log [$];
  int          pulse_count = 0;
  int          wait_cycles = 0;

  function automatic logic [NW-1:0] mask_of(input int c);
    return wm[c*NW +: NW];
  endfunction

  function automatic bit any_exp();
    bit r = 1'b0;
    for (int c = 0; c < NC; c++) r |= exp_valid[c];
    return r;
  endfunction

  // Smallest way count whose cumulative (saturated) hits are within gap of the full count.
  function automatic logic [NW-1:0] predict(input int c);
    longint s = 0;
    longint cum [NW];
    longint total;
    int ways, eff;
    logic [NW-1:0] m;
    for (int k = 0; k < NW; k++) begin
      s += hist[c][k];
      cum[k] = (s > SAT) ? SAT : s;
    end
    total = cum[NW-1];
    ways = NW;
    for (int k = NW-1; k >= 0; k--) if (cum[k] + longint'(gap) >= total) ways = k + 1;
    eff = (min_ways == 0) ? 1 : ((int'(min_ways) > NW) ? NW : int'(min_ways));
    if (ways < eff) ways = eff;
    m = '0;
    for (int i = 0; i < ways; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NC; c++) begin
      for (int k = 0; k < NW; k++) hist[c][k] = 0;
      acc_m[c] = 0;
      blocked[c] = 1'b0;
      release_m[c] = 1'b0;
      exp_valid[c] = 1'b0;
      model_mask[c] = '1;
    end
    wait_cycles = 0;
  endtask

  task automatic compare_step();
    int ch;
    if (update_valid) begin
      ch = int'(update_channel);
      pulse_log.push_back(ch);
      pulse_count++;
      wait_cycles = 0;
      checks++;
      if (ch >= NC || !exp_valid[ch]) begin
        errors++;
        $display("FAIL unexpected_pulse: channel %0d pulsed with no evaluation outstanding", ch);
      end else begin
        model_mask[ch] = exp_mask[ch];
        exp_valid[ch] = 1'b0;
        release_m[ch] = 1'b1;
      end
    end else if (any_exp()) begin
      wait_cycles++;
      if (wait_cycles > 40) begin
        checks++;
        errors++;
        $display("FAIL pulse_timeout: no update pulse within 40 cycles of an outstanding evaluation");
        for (int c = 0; c < NC; c++) exp_valid[c] = 1'b0;
        wait_cycles = 0;
      end
    end
    for (int c = 0; c < NC; c++) begin
      checks++;
      if (mask_of(c) !== model_mask[c]) begin
        errors++;
        $display("FAIL mask_ch%0d: actual %h required %h", c, mask_of(c), model_mask[c]);
      end
    end
  endtask

  // Absorbs the inputs the DUT will sample at the coming rising edge.
  task automatic model_step();
    int c, p;
    if (!reset_n || !enable) begin
      model_clear();
    end else begin
      if (access_valid) begin
        c = int'(access_channel);
        if (c < NC && !blocked[c]) begin
          acc_m[c]++;
          p = int'(hit_pos);
          if (p < NW) hist[c][p]++;
          if (longint'(acc_m[c]) == (longint'(1) << power)) begin
            blocked[c] = 1'b1;
            exp_mask[c] = predict(c);
            exp_valid[c] = 1'b1;
          end
        end
      end
      for (int i = 0; i < NC; i++) begin
        if (release_m[i]) begin
          release_m[i] = 1'b0;
          blocked[i] = 1'b0;
          acc_m[i] = 0;
          for (int k = 0; k < NW; k++) hist[i][k] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (cmp_en) compare_step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic acc(input int ch, input int pos);
    access_valid = 1'b1;
    access_channel = 2'(ch);
    hit_pos = 5'(pos);
    tick();
    access_valid = 1'b0;
  endtask

  task automatic burst(input int ch, input int pos, input int n);
    repeat (n) acc(ch, pos);
  endtask

  task automatic drain();
    int t = 0;
    while (any_exp() && t < 100) begin
      tick();
      t++;
    end
    idle(2);
    checks++;
    if (any_exp()) begin
      errors++;
      $display("FAIL drain: evaluation still outstanding after %0d cycles", t);
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc, lat, n;
    model_clear();
    reset_n = 1'b0; enable = 1'b1; power = 5'd4; gap = '0; min_ways = 5'd1;
    access_valid = 1'b0; access_channel = '0; hit_pos = '0;
    idle(2);
    cmp_en = 1'b1;
    idle(1);
    check_val("reset_masks", wm, 64'hFFFF_FFFF_FFFF_FFFF);
    check_val("reset_update_valid", 64'(update_valid), 64'd0);
    check_val("reset_update_channel", 64'(update_channel), 64'd0);
    reset_n = 1'b1;
    idle(1);

    // 16 hits at depth 3 -> four ways, exactly one pulse
    pc = pulse_count;
    burst(0, 3, 16);
    drain();
    check_val("depth3_mask", 64'(mask_of(0)), 64'h000F);
    check_val("depth3_pulses", 64'(pulse_count - pc), 64'd1);

    // 12 MRU hits + 4 at depth 9 against two gap settings
    gap = 8'd4;
    burst(0, 0, 12); burst(0, 9, 4);
    drain();
    check_val("gap4_mask", 64'(mask_of(0)), 64'h0001);
    gap = 8'd3;
    burst(0, 0, 12); burst(0, 9, 4);
    drain();
    check_val("gap3_mask", 64'(mask_of(0)), 64'h03FF);

    // all misses on channel 2 with a floor of four ways; pulse latency from the last access
    gap = '0; min_ways = 5'd4;
    burst(2, 16, 15);
    acc(2, 20);
    lat = 0;
    while (!update_valid && lat < 10) begin
      tick();
      lat++;
    end
    check_val("miss_latency", 64'(lat), 64'd3);
    drain();
    check_val("miss_min4_mask", 64'(mask_of(2)), 64'h000F);

    // floor clamping: 0 behaves as 1, above NUM_WAYS behaves as NUM_WAYS
    min_ways = 5'd0;
    burst(2, 31, 16);
    drain();
    check_val("min0_mask", 64'(mask_of(2)), 64'h0001);
    min_ways = 5'd20;
    burst(1, 0, 16);
    drain();
    check_val("min20_mask", 64'(mask_of(1)), 64'hFFFF);

    // ch3 then ch1 finish while ch0 is evaluated; ch1 must be served first
    min_ways = 5'd1;
    burst(3, 1, 15);
    burst(1, 2, 15);
    burst(0, 0, 16);
    acc(3, 1);
    acc(1, 2);
    burst(3, 10, 8);
    drain();
    n = pulse_log.size();
    check_val("order_first", 64'(pulse_log[n-3]), 64'd0);
    check_val("order_second", 64'(pulse_log[n-2]), 64'd1);
    check_val("order_third", 64'(pulse_log[n-1]), 64'd3);
    check_val("order_ch1_mask", 64'(mask_of(1)), 64'h0007);
    check_val("order_ch3_mask", 64'(mask_of(3)), 64'h0003);

    // saturation at 255 and a gap that would wrap an 8-bit sum
    power = 5'd9;
    burst(0, 5, 300);
    burst(0, 0, 212);
    drain();
    check_val("saturate_mask", 64'(mask_of(0)), 64'h003F);
    gap = 8'd255;
    burst(0, 0, 512);
    drain();
    check_val("gap_overflow_mask", 64'(mask_of(0)), 64'h0001);

    // dropping enable mid-epoch discards the partial epoch and opens every mask
    power = 5'd4; gap = '0;
    burst(2, 7, 8);
    enable = 1'b0;
    idle(1);
    check_val("disable_masks", wm, 64'hFFFF_FFFF_FFFF_FFFF);
    enable = 1'b1;
    burst(2, 16, 16);
    drain();
    check_val("reenable_mask", 64'(mask_of(2)), 64'h0001);

    // reset in the middle of a long scan abandons it silently
    burst(0, 15, 16);
    idle(5);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    pc = pulse_count;
    idle(30);
    check_val("reset_scan_pulses", 64'(pulse_count - pc), 64'd0);
    check_val("reset_scan_masks", wm, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
